// File: rtl/l2_fetch_arbiter.sv
// Round-robin arbiter sharing the single L2 fetch port among NREQ L1 requesters.
// Optional watchdog built when L2_FETCH_ARBITER_TIMEOUT_EN is defined.
module l2_fetch_arbiter #(
  parameter int NREQ           = 2,
  parameter int NFU            = 2,
  parameter int ADDRESS_LENGTH = 56,
  parameter int TIMEOUT        = 255,
  localparam int CACHELINEWIDTH = NFU * 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NREQ-1:0]                  req_valid,
  input  logic [NREQ*ADDRESS_LENGTH-1:0]   req_address,
  output logic [NREQ-1:0]                  req_done,
  output logic [CACHELINEWIDTH-1:0]        req_data,
  output logic                             req_err,
  output logic                             busy,
  output logic [ADDRESS_LENGTH-1:0]        l2_address,
  output logic                             l2_doFetch,
  input  logic                             l2_doneFetch,
  input  logic [CACHELINEWIDTH-1:0]        l2_data
);

  localparam int LGW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
    $error("l2_fetch_arbiter: NREQ must be 2..8 and TIMEOUT 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                     state;
  state_t                     state_next;
  logic [LGW-1:0]             last_grant;
  logic [NREQ-1:0]            lg_onehot;
  logic [NREQ-1:0]            cand;
  logic                       grant_found;
  logic [LGW-1:0]             grant_idx;
  logic [ADDRESS_LENGTH-1:0]  addr_arr [NREQ];
  logic                       done_hit;
  logic                       tmo_hit;

  logic [LGW-1:0]             last_grant_d;
  logic [ADDRESS_LENGTH-1:0]  l2_address_d;
  logic                       l2_do_fetch_d;
  logic [NREQ-1:0]            req_done_d;
  logic [CACHELINEWIDTH-1:0]  req_data_d;

  for (genvar g = 0; g < NREQ; g++) begin : g_addr
    assign addr_arr[g] = req_address[g*ADDRESS_LENGTH +: ADDRESS_LENGTH];
  end

  assign lg_onehot = NREQ'(1) << last_grant;
  assign done_hit  = (state == BUSY) && l2_doneFetch;

  // Handshake: a requester raises req_valid with a stable address and holds both
  // until it sees its one-cycle req_done pulse; req_data/req_err are valid only
  // in that cycle. On the L2 side doFetch is held until one doneFetch is seen.

`ifdef L2_FETCH_ARBITER_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT - 1);
  logic [7:0] tmo_cnt;

  // Fires on the TIMEOUT-th cycle spent in BUSY; a simultaneous done wins.
  assign tmo_hit = (state == BUSY) && !l2_doneFetch && (tmo_cnt == TMO_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= 8'd0;
    end else if (state_next == BUSY && state != BUSY) begin
      tmo_cnt <= 8'd0;
    end else if (state == BUSY) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_err <= 1'b0;
    end else if (done_hit) begin
      req_err <= 1'b0;
    end else if (tmo_hit) begin
      req_err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign req_err = 1'b0;
`endif

  // In DRAIN the just-served requester still shows a stale req_valid, so mask it.
  always_comb begin
    logic [LGW-1:0] pos;
    cand = req_valid;
    if (state == DRAIN) begin
      cand = req_valid & ~lg_onehot;
    end
    grant_found = 1'b0;
    grant_idx   = last_grant;
    pos         = '0;
    for (int k = 1; k <= NREQ; k++) begin
      pos = LGW'((int'(last_grant) + k) % NREQ);
      if (!grant_found && cand[pos]) begin
        grant_found = 1'b1;
        grant_idx   = pos;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_found) state_next = BUSY;
      BUSY:    if (done_hit || tmo_hit) state_next = DRAIN;
      DRAIN:   state_next = grant_found ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    last_grant_d  = last_grant;
    l2_address_d  = l2_address;
    l2_do_fetch_d = l2_doFetch;
    req_done_d    = '0;
    req_data_d    = req_data;
    case (state)
      IDLE, DRAIN: begin
        if (grant_found) begin
          last_grant_d  = grant_idx;
          l2_address_d  = addr_arr[grant_idx];
          l2_do_fetch_d = 1'b1;
        end
      end
      BUSY: begin
        if (done_hit) begin
          req_done_d    = lg_onehot;
          req_data_d    = l2_data;
          l2_do_fetch_d = 1'b0;
        end else if (tmo_hit) begin
          req_done_d    = lg_onehot;
          req_data_d    = '0;
          l2_do_fetch_d = 1'b0;
        end
      end
      default: begin
        l2_do_fetch_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= LGW'(NREQ - 1);
      l2_address <= '0;
      l2_doFetch <= 1'b0;
      req_done   <= '0;
      req_data   <= '0;
      busy       <= 1'b0;
    end else begin
      last_grant <= last_grant_d;
      l2_address <= l2_address_d;
      l2_doFetch <= l2_do_fetch_d;
      req_done   <= req_done_d;
      req_data   <= req_data_d;
      busy       <= (state_next == BUSY);
    end
  end

endmodule
